// File: rtl/riscv_pkg.sv
// Shared definitions for the front of the RISC-V pipeline: encodings, reset PC and fetch FSM states.
package riscv_pkg;

   localparam logic [31:0] NOP              = 32'h0000_0013;
   localparam int unsigned DEFAULT_RESET_PC = 0;

   // ALU_Control encodings; the branch group shares the 010 prefix.
   localparam logic [5:0] ALU_BEQ  = 6'b010_000;
   localparam logic [5:0] ALU_BNE  = 6'b010_001;
   localparam logic [5:0] ALU_BLT  = 6'b010_100;
   localparam logic [5:0] ALU_BGE  = 6'b010_101;
   localparam logic [5:0] ALU_BLTU = 6'b010_110;
   localparam logic [5:0] ALU_BGEU = 6'b010_111;
   localparam logic [5:0] ALU_JAL  = 6'b011_111;
   localparam logic [5:0] ALU_JALR = 6'b111_111;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } fetch_state_e;

   function automatic logic is_branch_op(input logic [5:0] alu_control);
      return alu_control[5:3] == 3'b010;
   endfunction

endpackage

// File: rtl/pc_redirect_mux.sv
// Priority select of fetch redirect targets: jalr > branch > jal (execute is older than decode).
module pc_redirect_mux #(
   parameter int ADDRESS_BITS = 16
) (
   input  logic                    jalr_i,
   input  logic [ADDRESS_BITS-1:0] jalr_target_i,
   input  logic                    branch_i,
   input  logic [ADDRESS_BITS-1:0] branch_target_i,
   input  logic                    jal_i,
   input  logic [ADDRESS_BITS-1:0] jal_target_i,
   output logic                    redirect_o,
   output logic [ADDRESS_BITS-1:0] target_o
);

   localparam logic [ADDRESS_BITS-1:0] ALIGN_MASK = ~ADDRESS_BITS'(3);

   logic [2:0] sel;

   always_comb begin
      sel = 3'b000;
      if (jalr_i)        sel = 3'b100;
      else if (branch_i) sel = 3'b010;
      else if (jal_i)    sel = 3'b001;
   end

   assign redirect_o = |sel;

   // AND-OR over a one-hot select; low bits cleared so fetch stays word aligned.
   assign target_o = (({ADDRESS_BITS{sel[2]}} & jalr_target_i)
                    | ({ADDRESS_BITS{sel[1]}} & branch_target_i)
                    | ({ADDRESS_BITS{sel[0]}} & jal_target_i)) & ALIGN_MASK;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC generation, synchronous imem interface, decode-facing output registers.
//
// state | meaning
// FILL  | pipeline refilling after reset/redirect, no valid instruction yet
// RUN   | streaming one instruction per cycle to decode
// HOLD  | hazard stall, everything frozen
module fetch_unit
   import riscv_pkg::*;
#(
   parameter int          ADDRESS_BITS = 16,
   parameter int          DATA_WIDTH   = 32,
   parameter int unsigned RESET_PC     = DEFAULT_RESET_PC
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    stall,
   input  logic                    branch,
   input  logic [ADDRESS_BITS-1:0] branch_target,
   input  logic                    jalr,
   input  logic [ADDRESS_BITS-1:0] jalr_target,
   input  logic                    jal,
   input  logic [ADDRESS_BITS-1:0] jal_target,
   output logic [ADDRESS_BITS-1:0] imem_addr,
   input  logic [DATA_WIDTH-1:0]   imem_rdata,
   output logic [DATA_WIDTH-1:0]   instruction,
   output logic [ADDRESS_BITS-1:0] instr_pc,
   output logic                    instr_valid,
   output logic                    flush,
   output logic [31:0]             fetch_count
);

   localparam logic [ADDRESS_BITS-1:0] PC_RST = ADDRESS_BITS'(RESET_PC);

   logic [ADDRESS_BITS-1:0] fetch_pc_q,    fetch_pc_d;
   logic [ADDRESS_BITS-1:0] inflight_pc_q, inflight_pc_d;
   logic                    inflight_valid_q, inflight_valid_d;
   logic [DATA_WIDTH-1:0]   instr_q,       instr_d;
   logic [ADDRESS_BITS-1:0] instr_pc_q,    instr_pc_d;
   logic                    instr_valid_q, instr_valid_d;
   logic [31:0]             count_q,       count_d;
   fetch_state_e            state_q,       state_d;

   logic                    redirect;
   logic [ADDRESS_BITS-1:0] target;

   pc_redirect_mux #(.ADDRESS_BITS(ADDRESS_BITS)) u_redirect (
      .jalr_i          (jalr),
      .jalr_target_i   (jalr_target),
      .branch_i        (branch),
      .branch_target_i (branch_target),
      .jal_i           (jal),
      .jal_target_i    (jal_target),
      .redirect_o      (redirect),
      .target_o        (target)
   );

   // Re-reading the in-flight address keeps imem_rdata stable across a stall.
   assign imem_addr = stall ? inflight_pc_q : fetch_pc_q;

   always_comb begin
      fetch_pc_d       = fetch_pc_q;
      inflight_pc_d    = inflight_pc_q;
      inflight_valid_d = inflight_valid_q;
      instr_d          = instr_q;
      instr_pc_d       = instr_pc_q;
      instr_valid_d    = instr_valid_q;
      count_d          = count_q;
      state_d          = state_q;

      if (redirect) begin
         fetch_pc_d       = target;
         inflight_valid_d = 1'b0;
         instr_valid_d    = 1'b0;
         state_d          = FILL;
      end else if (stall) begin
         state_d = HOLD;
      end else begin
         fetch_pc_d       = fetch_pc_q + ADDRESS_BITS'(4);
         inflight_pc_d    = fetch_pc_q;
         inflight_valid_d = 1'b1;
         instr_d          = imem_rdata;
         instr_pc_d       = inflight_pc_q;
         instr_valid_d    = inflight_valid_q;
         if (instr_valid_q) count_d = count_q + 32'd1;
         case (state_q)
            FILL:    state_d = inflight_valid_q ? RUN : FILL;
            RUN:     state_d = RUN;
            HOLD:    state_d = inflight_valid_q ? RUN : FILL;
            default: state_d = FILL;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_pc_q       <= PC_RST;
         inflight_pc_q    <= PC_RST;
         inflight_valid_q <= 1'b0;
         instr_q          <= DATA_WIDTH'(NOP);
         instr_pc_q       <= '0;
         instr_valid_q    <= 1'b0;
         count_q          <= '0;
         state_q          <= FILL;
      end else begin
         fetch_pc_q       <= fetch_pc_d;
         inflight_pc_q    <= inflight_pc_d;
         inflight_valid_q <= inflight_valid_d;
         instr_q          <= instr_d;
         instr_pc_q       <= instr_pc_d;
         instr_valid_q    <= instr_valid_d;
         count_q          <= count_d;
         state_q          <= state_d;
      end
   end

   assign flush       = redirect & ~reset;
   assign instruction = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = instr_valid_q;
   assign fetch_count = count_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage at the front of the RISC-V pipeline.
- Generates the PC and drives a synchronous instruction memory (1-cycle read latency).
- Presents registered instruction/PC pairs to decode, which produces operand_A/operand_B/ALU_Control for the ALU.
- Consumes the ALU's branch flag and jump targets back from execute to redirect fetch, and honours a hazard stall.

Parameters:
- ADDRESS_BITS, 16, byte-PC width; all PC/target arithmetic is modulo 2^ADDRESS_BITS.
- DATA_WIDTH, 32, instruction width.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hazard unit freezes fetch and the decode-facing outputs.
- branch  in  1  ALU branch flag from execute (conditional taken).
- branch_target  in  ADDRESS_BITS  execute-computed branch target.
- jalr  in  1  JALR resolved in execute.
- jalr_target  in  ADDRESS_BITS  rs1+imm from ALU pass-through.
- jal  in  1  JAL resolved in decode.
- jal_target  in  ADDRESS_BITS  decode-computed JAL target.
- imem_addr  out  ADDRESS_BITS  byte address to instruction memory.
- imem_rdata  in  DATA_WIDTH  mem[imem_addr of previous cycle].
- instruction  out  DATA_WIDTH  instruction to decode.
- instr_pc  out  ADDRESS_BITS  PC of instruction.
- instr_valid  out  1  instruction/instr_pc are meaningful.
- flush  out  1  one-cycle pulse on any redirect; decode/ID-EX squash.
- fetch_count  out  32  count of instructions delivered to decode.

Behaviour:
- Reset (synchronous, active-high): fetch_pc=RESET_PC, inflight_valid=0, instruction=32'h00000013 (NOP), instr_pc=0, instr_valid=0, flush=0, fetch_count=0, state=FILL. Reset overrides every other input in the same cycle.
- Internal pipeline: fetch_pc → (memory) → inflight_pc/inflight_valid, paired with imem_rdata → output registers.
- imem_addr = stall ? inflight_pc : fetch_pc. Re-reading the in-flight address keeps imem_rdata stable during a stall.
- Redirect priority: jalr > branch > jal. Execute is older than decode. jalr+branch together: jalr wins.
  - Selected target has bits [1:0] forced to 0.
  - One-hot select lives in the sub-module.
- Redirect cycle (any of the three asserted), regardless of stall:
  - fetch_pc <= target; inflight_valid <= 0; instr_valid <= 0; flush=1 for that cycle only; state <= FILL.
- Non-redirect, stall=1: fetch_pc, inflight_*, instruction, instr_pc, instr_valid, fetch_count all hold; state HOLD.
- Non-redirect, stall=0:
  - fetch_pc <= fetch_pc+4 (wraps to 0 at 2^ADDRESS_BITS).
  - inflight_pc <= fetch_pc; inflight_valid <= 1.
  - Output regs <= {imem_rdata, inflight_pc, inflight_valid}.
- fetch_count increments when instr_valid=1 and stall=0 and no redirect. Wraps at 2^32.
- FSM:
  - FILL → RUN once instr_valid would become 1.
  - RUN ↔ HOLD on stall.
  - Any state → FILL on redirect.
- Latency:
  - First valid output 2 cycles after reset deassertion (instr_pc=RESET_PC).
  - Redirect penalty: redirect in cycle R, target appears with instr_valid=1 in cycle R+3.
- Redirect must never let a wrong-path instruction reach decode with instr_valid=1.

Decomposition:
- Shared package riscv_pkg:
  - NOP encoding 32'h00000013.
  - Default RESET_PC.
  - ALU_Control encodings (branch group 010_xxx, JAL 011111, JALR 111111).
  - FSM state typedef {FILL, RUN, HOLD}.
- Sub-module pc_redirect_mux: priority select of jalr/branch/jal targets with LSB alignment; outputs redirect and target.

Test Plan:
- Reset then free run, imem[i]=i: instr_valid=1 from cycle 2; instr_pc 0,4,8,12 on consecutive cycles; instructions match; fetch_count=4 after 4 outputs.
- stall=1 for 3 cycles while instr_pc=8: instruction/instr_pc/fetch_count frozen; after release, sequence resumes at 12 with no duplicate and no skip.
- branch=1, branch_target=0x40 in cycle R: flush=1 in R only; instr_valid=0 in R+1 and R+2; instr_pc=0x40 with valid in R+3.
- jalr=1 (target 0x23) and branch=1 (target 0x80) together: redirect to 0x20; jal=1 plus branch=1: branch target wins.
- Redirect while stall=1: redirect taken; stall ignored that cycle; target delivered at R+3 once stall is low.
- fetch_pc=2^ADDRESS_BITS−4 free-running: next instr_pc is 0; reset asserted mid-stall returns all outputs to reset values on the next edge.
